// File: rtl/csa_resolve_serial.sv
// csa_resolve_serial: digit-serial resolver, (sum row + carry row) -> one WIDTH+1 bit binary result; macro CSA_RESOLVE_EARLY_DONE_EN.
// Latency: N=WIDTH/DIGIT cycles accept->out_valid (k+1 cycles with early-done when upper digits are zero).
// Backpressure: single transaction in flight; in_ready low in RUN/DONE, result held in DONE until out_ready.
module csa_resolve_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic             busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("csa_resolve_serial: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] sum_q, carry_q;
    logic [WIDTH:0]   res_q, res_d;
    logic [KW-1:0]    k_q;
    logic             c_q;
    logic [DIGIT:0]   digit_sum;
    logic             finish;
    int               top;

    // One digit of ripple per cycle; the carry-out lands just above the digit so that
    // a run that ends here (last digit or early-done) leaves a complete result.
    always_comb begin
        digit_sum = {1'b0, sum_q[int'(k_q)*DIGIT +: DIGIT]}
                  + {1'b0, carry_q[int'(k_q)*DIGIT +: DIGIT]}
                  + {{DIGIT{1'b0}}, c_q};
        top   = (int'(k_q) + 1) * DIGIT;
        res_d = res_q;
        res_d[int'(k_q)*DIGIT +: DIGIT] = digit_sum[DIGIT-1:0];
        for (int i = 0; i <= WIDTH; i++) begin
            if (i == top) begin
                res_d[i] = digit_sum[DIGIT];
            end else if (i > top) begin
                res_d[i] = 1'b0;
            end
        end
`ifdef CSA_RESOLVE_EARLY_DONE_EN
        finish = (k_q == K_LAST) || (((sum_q | carry_q) >> top) == '0);
`else
        finish = (k_q == K_LAST);
`endif
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (finish) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            res_q   <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            sum_q   <= in_sum;
            carry_q <= in_carry;
            k_q     <= '0;
            c_q     <= 1'b0;
        end else if (state_q == RUN) begin
            res_q <= res_d;
            c_q   <= digit_sum[DIGIT];
            k_q   <= k_q + 1'b1;
        end
    end

    assign out_result = res_q;

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Self-checking bench for csa_resolve_serial: scoreboard queue of expected sums and latencies.
`timescale 1ns/1ps
module tb_csa_resolve_serial;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_sum = '0;
    logic [WIDTH-1:0] in_carry = '0;
    logic             in_ready, out_valid, busy;
    logic [WIDTH:0]   out_result;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic [WIDTH:0] exp_res_q[$];
    int             exp_lat_q[$];

    csa_resolve_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_lat(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
`ifdef CSA_RESOLVE_EARLY_DONE_EN
        logic [WIDTH-1:0] o;
        o = s | c;
        for (int k = 0; k < N - 1; k++) begin
            if ((o >> ((k + 1) * DIGIT)) == '0) return k + 1;
        end
        return N;
`else
        return N;
`endif
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic drive_accept(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        int n;
        n = 0;
        in_sum = s; in_carry = c; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        exp_res_q.push_back({1'b0, s} + {1'b0, c});
        exp_lat_q.push_back(exp_lat(s, c));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [WIDTH:0] res, output int lat, output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok  = out_valid;
        res = out_result;
        lat = cyc - accept_cyc;
    endtask

    task automatic pop_exp(output logic [WIDTH:0] r, output int l);
        if (exp_res_q.size() == 0) begin
            r = 'x;
            l = -1;
        end else begin
            r = exp_res_q.pop_front();
            l = exp_lat_q.pop_front();
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_result=%h busy=%b required 1 0 0 0",
                     in_ready, out_valid, out_result, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] s_tab [3];
        logic [WIDTH-1:0] c_tab [3];
        logic [WIDTH:0]   res, er;
        int               lat, el;
        bit               ok;
        s_tab = '{16'h1234, 16'hFFFF, 16'hFFFF};
        c_tab = '{16'h0F0F, 16'h0001, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            drive_accept(s_tab[i], c_tab[i]);
            tests_run++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_busy[%0d]: busy=%b in_ready=%b required 1 0", i, busy, in_ready);
            end
            wait_result(res, lat, ok);
            pop_exp(er, el);
            tests_run++;
            if (!ok || res !== er) begin
                tests_failed++;
                $display("FAIL basic_result[%0d]: got %h required %h", i, res, er);
            end
            tests_run++;
            if (lat !== el) begin
                tests_failed++;
                $display("FAIL basic_latency[%0d]: got %0d required %0d", i, lat, el);
            end
            handshake();
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_release[%0d]: in_ready=%b out_valid=%b required 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [WIDTH:0] res, er;
        int             lat, el;
        bit             ok;
        drive_accept(16'h1111, 16'h2222);
        in_sum = 16'hAAAA; in_carry = 16'h5555; in_valid = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_in_ready_run: got %b required 0", in_ready);
        end
        wait_result(res, lat, ok);
        pop_exp(er, el);
        tests_run++;
        if (!ok || res !== er || lat !== el) begin
            tests_failed++;
            $display("FAIL bp_result: got %h lat %0d required %h lat %0d", res, lat, er, el);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== er || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_result=%h in_ready=%b required 1 %h 0",
                         i, out_valid, out_result, in_ready, er);
            end
        end
        in_valid = 1'b0;
        handshake();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [WIDTH:0] res, er;
        int             lat, el;
        bit             ok;
        drive_accept(16'h1234, 16'h4321);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b out_result=%h busy=%b required 0 1 0 0",
                     out_valid, in_ready, out_result, busy);
        end
        exp_res_q.delete();
        exp_lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_accept(16'h0001, 16'h0001);
        wait_result(res, lat, ok);
        pop_exp(er, el);
        tests_run++;
        if (!ok || res !== er || lat !== el) begin
            tests_failed++;
            $display("FAIL midrun_next: got %h lat %0d required %h lat %0d", res, lat, er, el);
        end
        handshake();
    endtask

    task automatic test_early_done;
        logic [WIDTH-1:0] s_tab [3];
        logic [WIDTH-1:0] c_tab [3];
        logic [WIDTH:0]   res, er;
        int               lat, el;
        bit               ok;
        s_tab = '{16'h0003, 16'h00FF, 16'h8000};
        c_tab = '{16'h0005, 16'h0001, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            drive_accept(s_tab[i], c_tab[i]);
            wait_result(res, lat, ok);
            pop_exp(er, el);
            tests_run++;
            if (!ok || res !== er) begin
                tests_failed++;
                $display("FAIL early_result[%0d]: got %h required %h", i, res, er);
            end
            tests_run++;
            if (lat !== el) begin
                tests_failed++;
                $display("FAIL early_latency[%0d]: got %0d required %0d", i, lat, el);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH:0] res, er;
        int             lat, el, t_valid;
        bit             ok;
        out_ready = 1'b1;
        drive_accept(16'h0F0F, 16'h00F1);
        wait_result(res, lat, ok);
        t_valid = cyc;
        pop_exp(er, el);
        tests_run++;
        if (!ok || res !== er || lat !== el) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h lat %0d required %h lat %0d", res, lat, er, el);
        end
        drive_accept(16'h7000, 16'h9001);
        tests_run++;
        if (accept_cyc !== t_valid + 2) begin
            tests_failed++;
            $display("FAIL b2b_accept_edge: got %0d required %0d", accept_cyc, t_valid + 2);
        end
        wait_result(res, lat, ok);
        pop_exp(er, el);
        tests_run++;
        if (!ok || res !== er || lat !== el) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h lat %0d required %h lat %0d", res, lat, er, el);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_early_ready: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] s, c;
        logic [WIDTH:0]   er;
        int               el, n, received;
        bit               done;
        received = 0;
        for (int i = 0; i < 1000; i++) begin
            s = WIDTH'($urandom);
            c = WIDTH'($urandom);
            s = s >> (DIGIT * $urandom_range(0, N - 1));
            c = c >> (DIGIT * $urandom_range(0, N - 1));
            drive_accept(s, c);
            done = 1'b0;
            n = 0;
            while (!done && n < 500) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready) begin
                    pop_exp(er, el);
                    received++;
                    tests_run++;
                    if (out_result !== er) begin
                        tests_failed++;
                        $display("FAIL random_result[%0d]: got %h required %h", i, out_result, er);
                    end
                    done = 1'b1;
                end
                @(negedge clk);
                n++;
            end
            out_ready = 1'b0;
            if (!done) begin
                tests_run++; tests_failed++;
                $display("FAIL random_timeout[%0d]: out_valid=%b required 1", i, out_valid);
            end
        end
        tests_run++;
        if (received !== 1000 || exp_res_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL random_count: received %0d pending %0d required 1000 0", received, exp_res_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_early_done();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
